calc_sequencer: RTL

Operation sequencer for the 4-bit binary calculator datapath. It steps the user through three entries on one enter button: operand A, then operand B, then the operation. It then computes the result and drives the select of the display 2:1 mux bank, which shows either the live switch value or the result. It sits between the debounced board inputs (switches, enter and clear buttons) and the mux/display datapath.

---
 rtl/calc_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/calc_sequencer.sv
// calc_sequencer: three-entry operation sequencer for the 4-bit calculator.
// One enter button steps through operand A, operand B and the op code.
// The block then computes a registered result and selects it onto the display
// mux while in SHOW.
//
// Handshake: there is no valid/ready pair here. A "press" is the single-cycle
// rising edge of the debounced enter level. It is consumed by the state it is
// sampled in. EXEC ignores presses. clear overrides any press in the same cycle.
module calc_sequencer #(
  parameter int WIDTH       = 4,
  parameter int SHOW_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enter,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] a_reg,
  output logic [WIDTH-1:0] b_reg,
  output logic [1:0]       op_reg,
  output logic [WIDTH:0]   result,
  output logic             result_valid,
  output logic             disp_sel,
  output logic [2:0]       state,
  output logic             busy
);

  // Hold counter sized to reach SHOW_CYCLES-1; a 0 setting never compares
  localparam int CW = (SHOW_CYCLES > 2) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((SHOW_CYCLES == 0) ? 0 : SHOW_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GOT_A = 3'd1,
    S_GOT_B = 3'd2,
    S_EXEC  = 3'd3,
    S_SHOW  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_enter_q;
  logic             w_press;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic [WIDTH:0]   r_result;
  logic [WIDTH:0]   w_alu;
  logic [CW-1:0]    r_cnt;
  logic             w_cnt_done;
  logic             w_cap_a;
  logic             w_cap_b;
  logic             w_cap_op;
  logic             w_exec;
  logic             w_show;
  logic             w_busy;

  assign w_press    = enter & ~r_enter_q;
  assign w_cnt_done = (SHOW_CYCLES != 0) && (r_cnt == CNT_LAST);

  // Result function; the extra MSB carries the carry/borrow for ADD/SUB
  always_comb begin
    w_alu = '0;
    case (r_op)
      2'b00:   w_alu = {1'b0, r_a} + {1'b0, r_b};
      2'b01:   w_alu = {1'b0, r_a} - {1'b0, r_b};
      2'b10:   w_alu = {1'b0, r_a & r_b};
      default: w_alu = {1'b0, r_a | r_b};
    endcase
  end

  // Next-state and per-state strobes; clear wins over everything
  always_comb begin
    w_next   = r_state;
    w_cap_a  = 1'b0;
    w_cap_b  = 1'b0;
    w_cap_op = 1'b0;
    w_exec   = 1'b0;
    w_show   = 1'b0;
    w_busy   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_press) begin
          w_cap_a = 1'b1;
          w_next  = S_GOT_A;
        end
      end
      S_GOT_A: begin
        if (w_press) begin
          w_cap_b = 1'b1;
          w_next  = S_GOT_B;
        end
      end
      S_GOT_B: begin
        if (w_press) begin
          w_cap_op = 1'b1;
          w_next   = S_EXEC;
        end
      end
      S_EXEC: begin
        w_busy = 1'b1;
        w_exec = 1'b1;
        w_next = S_SHOW;
      end
      S_SHOW: begin
        w_show = 1'b1;
        if (w_press || w_cnt_done) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (clear) begin
      w_next   = S_IDLE;
      w_cap_a  = 1'b0;
      w_cap_b  = 1'b0;
      w_cap_op = 1'b0;
      w_exec   = 1'b0;
    end
  end

  // State register and enter edge detector (edge register updates even on clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_enter_q <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_enter_q <= enter;
    end
  end

  // Operand, op code, result and hold counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_cnt    <= '0;
    end else if (clear) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_cap_a)  r_a  <= data_in;
      if (w_cap_b)  r_b  <= data_in;
      if (w_cap_op) r_op <= data_in[1:0];
      if (w_exec) begin
        r_result <= w_alu;
        r_cnt    <= '0;
      end else if (w_show && !w_press && !w_cnt_done) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign a_reg        = r_a;
  assign b_reg        = r_b;
  assign op_reg       = r_op;
  assign result       = r_result;
  assign result_valid = w_show;
  assign disp_sel     = w_show;
  assign busy         = w_busy;
  assign state        = r_state;

endmodule
